// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, buffer entry type and PC constants for
// the fetch sequencer. Optional feature macro: FETCH_ALIGN_CHECK_EN (adds
// the HALT state used after a misaligned redirect).
package fetch_pkg;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
    , HALT = 3'd4
`endif
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 2-entry (head + skid) valid/ready buffer carrying
// {instr, pc} toward decode, with a synchronous flush that drops both entries.
// The producer must not push while both entries are held and no pop occurs.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  output logic         out_valid,
  input  logic         out_ready,
  output fetch_entry_t out_data,
  output logic [1:0]   count
);

  logic         head_valid;
  logic         skid_valid;
  fetch_entry_t head;
  logic         pop;
  fetch_entry_t skid;

  assign pop       = head_valid && out_ready;
  assign out_valid = head_valid;
  assign out_data  = head;
  assign count     = {1'b0, head_valid} + {1'b0, skid_valid};

  // Head/skid update: pop shifts skid into head in the same edge as a push lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head       <= '0;
      skid       <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        head       <= skid;
        skid_valid <= push;
        if (push) skid <= push_data;
      end else begin
        head_valid <= push;
        if (push) head <= push_data;
      end
    end else if (push) begin
      if (!head_valid) begin
        head_valid <= 1'b1;
        head       <= push_data;
      end else begin
        skid_valid <= 1'b1;
        skid       <= push_data;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues valid/ack requests to instruction
// memory and feeds decode through a 2-entry buffer. Branch redirects flush
// buffered wrong-path words; an outstanding request is drained first.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- a misaligned redirect sets
// a sticky fetch_fault, is not taken, and the sequencer halts until reset.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic         armed;
  logic [31:0]  pc;
  logic [31:0]  pc_nxt;
  logic [31:0]  drain_target;
  logic [31:0]  drain_target_nxt;
  logic [31:0]  target;
  logic         pop;
  logic         push;
  logic         busy_no_ack;
  logic         halted;
  logic         bad_target;
  logic [1:0]   buf_count;
  logic [1:0]   occ_after;
  fetch_entry_t push_entry;
  fetch_entry_t buf_out;

  // Request and address are pure functions of registered state, so they only
  // move on clock edges; the address of a drained request is the unchanged pc.
  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = pc;
  assign pop         = instr_valid && instr_ready;
  assign push        = (state == FETCH) && imem_ack && !branch_valid;
  assign busy_no_ack = imem_req && !imem_ack;
  assign occ_after   = buf_count + 2'd1 - {1'b0, pop};
  assign target      = {branch_target[31:2], 2'b00};
  assign push_entry  = '{instr: imem_rdata, pc: pc};
  assign instr       = buf_out.instr;
  assign instr_pc    = buf_out.pc;
  assign pc_plus4    = instr_pc + PC_STEP;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  logic fault_nxt;
  logic halt_pending;
  logic halt_pending_nxt;

  assign bad_target  = |branch_target[1:0];
  assign halted      = (state == HALT);
  assign fetch_fault = fault_q;
`else
  logic unused_target_lsbs;

  assign unused_target_lsbs = ^branch_target[1:0];
  assign bad_target         = 1'b0;
  assign halted             = 1'b0;
  assign fetch_fault        = 1'b0;
`endif

  fetch_skid_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch_valid),
    .push      (push),
    .push_data (push_entry),
    .out_valid (instr_valid),
    .out_ready (instr_ready),
    .out_data  (buf_out),
    .count     (buf_count)
  );

  // Next state / next pc: normal sequencing first, then redirect overrides it.
  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    drain_target_nxt = drain_target;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_nxt        = fault_q;
    halt_pending_nxt = halt_pending;
`endif
    case (state)
      IDLE: begin
        if (armed) state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          pc_nxt = pc + PC_STEP;
          if (occ_after == 2'd2) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (pop) state_nxt = FETCH;
      end
      DRAIN: begin
        if (imem_ack) begin
          pc_nxt    = drain_target;
          state_nxt = FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
          if (halt_pending) state_nxt = HALT;
`endif
        end
      end
      default: begin
      end
    endcase

    if (branch_valid && !halted) begin
`ifdef FETCH_ALIGN_CHECK_EN
      // Once a misaligned redirect is seen the halt stays pending even if a
      // later aligned redirect arrives during the drain.
      if (bad_target || halt_pending) begin
        fault_nxt = fault_q | bad_target;
        if (busy_no_ack) begin
          state_nxt        = DRAIN;
          halt_pending_nxt = 1'b1;
        end else begin
          state_nxt = HALT;
        end
      end else
`endif
      if (busy_no_ack) begin
        state_nxt        = DRAIN;
        pc_nxt           = pc;
        drain_target_nxt = target;
      end else begin
        state_nxt = FETCH;
        pc_nxt    = target;
      end
    end
  end

  // Sequencer registers; armed delays the first request by one cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      armed        <= 1'b0;
      pc           <= RESET_PC;
      drain_target <= RESET_PC;
    end else begin
      state        <= state_nxt;
      armed        <= 1'b1;
      pc           <= pc_nxt;
      drain_target <= drain_target_nxt;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky fault flag and pending-halt marker, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q      <= 1'b0;
      halt_pending <= 1'b0;
    end else begin
      fault_q      <= fault_nxt;
      halt_pending <= halt_pending_nxt;
    end
  end
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences the instruction-fetch path: owns the program counter and arbitrates next-PC between sequential increment and branch redirect. Drives a valid/ack request handshake to instruction memory of variable latency (zero-wait allowed) and buffers fetched words toward decode with a valid/ready handshake. Flushes wrong-path words on redirect. Sits between the execute-stage branch resolution and the decode stage, replacing the free-running PC/mux/adder arrangement.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- branch_valid  in  1  single-cycle redirect request
- branch_target  in  32  redirect address
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ack  in  1  response valid; may coincide with the first imem_req cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- instr_valid  out  1  decode-side word valid
- instr_ready  in  1  decode accepts word
- instr  out  32  instruction word
- instr_pc  out  32  address of instr
- pc_plus4  out  32  instr_pc + 4, combinational, modulo 2^32
- fetch_fault  out  1  misaligned redirect seen (FETCH_ALIGN_CHECK_EN only)

## Operation
- States: IDLE, FETCH, HOLD, DRAIN (HALT with macro).
- IDLE: one cycle after reset release, then FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack the word and pc go to the output buffer; pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0). Without ack, stay; address held.
- Output buffer: 2 entries (head + skid). A new request is issued only while at least one entry is free after this cycle's pop. An ack that fills the last entry -> HOLD (imem_req=0). HOLD -> FETCH when an entry frees.
- Decode pop: instr_valid && instr_ready; head advances, and skid moves to head in the same edge.
- Redirect (branch_valid=1) has priority over everything:
  - flushes both buffer entries at the next edge; pc <= branch_target.
  - If no request is outstanding, or ack arrives in the same cycle, the word is discarded; FETCH at target next cycle.
  - If a request is outstanding without ack: DRAIN. imem_req stays high at the old address until ack; data is discarded, then FETCH at target.
  - A redirect during DRAIN replaces the pending target (latest wins).
  - A pop in the redirect cycle is still a valid handshake for that word.
- Reset mid-transaction: imem_req drops asynchronously. Memory tolerates the abandoned request.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, pc=RESET_PC, state IDLE.
- Release edge E0: IDLE. imem_req=1 after E1. With zero-wait ack, instr_valid=1 after E2.
- Steady state, zero-wait, instr_ready=1: one instruction per cycle.
- Redirect in cycle n: instr_valid=0 after edge n+1; imem_addr=target during cycle n+1; target word valid after n+2 (2-cycle penalty, zero-wait memory).
- imem_addr/imem_req change only on clock edges (or async reset).

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with branch_target[1:0]!=0 sets fetch_fault (sticky) and is not taken.
  - Buffers flush, any outstanding request drains, then state HALT: no requests until reset.
- Undefined: branch_target[1:0] forced to 0; fetch_fault tied 0; no HALT state.

## Structure
- Package fetch_pkg holds:
  - state enum;
  - PC_STEP=32'd4;
  - the default RESET_PC value.
- Sub-module fetch_skid_buffer: 2-entry valid/ready buffer carrying {instr, pc} with a synchronous flush input.
- Sequencer FSM, PC register and redirect logic stay in fetch_sequencer.

## Test plan
- Reset release, zero-wait memory, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8,…, one per cycle. First instr_valid two edges after release. pc_plus4=instr_pc+4.
- Memory acks 3 cycles after req -> imem_addr held stable for all 4 cycles; one word per 4 cycles.
- instr_ready=0 for 5 cycles in steady state -> exactly 2 words buffered, then imem_req=0 (HOLD). Release -> no loss or duplication, in order.
- branch_valid with target 0x100 while a request to 0x20 is waiting on ack -> DRAIN. Word for 0x20 never appears; next valid instr_pc=0x100.
- RESET_PC=32'hFFFF_FFF8 -> instr_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> fetch_fault=1, instr_valid=0, imem_req stays 0 until rst_n pulse.
